// File: rtl/wb_stage.sv
// wb_stage: RV32I writeback stage driving the register-file write port.
// Optional load timeout with load_err pulse when WB_LOAD_TIMEOUT_EN is defined.
module wb_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    input  logic [1:0]  in_wb_sel,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_pc_plus4,
    input  logic [2:0]  in_funct3,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_we
`ifdef WB_LOAD_TIMEOUT_EN
    ,
    output logic        load_err
`endif
);
    typedef enum logic {IDLE, LOAD_WAIT} state_t;
    state_t      state;
    logic [4:0]  rd_q;
    logic        reg_write_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_data;
    logic        accept;
    assign in_ready = (state == IDLE);
    assign accept   = in_valid && !flush;
    assign byte_v   = dmem_rdata[{off_q, 3'b000} +: 8];
    assign half_v   = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    // Unused funct3 encodings fall through to a full-word load.
    assign load_data = funct3_q == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
                       funct3_q == 3'b100 ? {24'b0, byte_v} :
                       funct3_q == 3'b001 ? {{16{half_v[15]}}, half_v} :
                       funct3_q == 3'b101 ? {16'b0, half_v} : dmem_rdata;
`ifdef WB_LOAD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wb_rd       <= '0;
            wb_data     <= '0;
            wb_we       <= 1'b0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
`ifdef WB_LOAD_TIMEOUT_EN
            load_err    <= 1'b0;
            cnt         <= '0;
`endif
        end else begin
            wb_we <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
            load_err <= 1'b0;
`endif
            if (state == IDLE) begin
                if (accept && in_wb_sel == 2'b01) begin
                    rd_q        <= in_rd;
                    reg_write_q <= in_reg_write;
                    funct3_q    <= in_funct3;
                    off_q       <= in_alu_result[1:0];
                    state       <= LOAD_WAIT;
`ifdef WB_LOAD_TIMEOUT_EN
                    cnt         <= '0;
`endif
                end else if (accept && in_reg_write && in_rd != 5'd0) begin
                    wb_rd   <= in_rd;
                    wb_data <= in_wb_sel == 2'b10 ? in_pc_plus4 : in_alu_result;
                    wb_we   <= 1'b1;
                end
            end else if (dmem_rvalid) begin
                if (reg_write_q && rd_q != 5'd0) begin
                    wb_rd   <= rd_q;
                    wb_data <= load_data;
                    wb_we   <= 1'b1;
                end
                state <= IDLE;
`ifdef WB_LOAD_TIMEOUT_EN
            end else if (cnt == CW'(TIMEOUT_CYCLES)) begin
                load_err <= 1'b1;
                state    <= IDLE;
            end else begin
                cnt <= cnt + 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table-driven and randomized bench for wb_stage.
module tb_wb_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 0, in_ready, flush = 0, in_reg_write = 0;
    logic [4:0]  in_rd = 0;
    logic [1:0]  in_wb_sel = 0;
    logic [31:0] in_alu_result = 0, in_pc_plus4 = 0, dmem_rdata = 0;
    logic [2:0]  in_funct3 = 0;
    logic        dmem_rvalid = 0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_we;
`ifdef WB_LOAD_TIMEOUT_EN
    logic        load_err;
`endif
    int errors = 0, checks = 0;
    logic [4:0]  last_rd = 0;
    logic [31:0] last_data = 0;

    wb_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
        .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4), .in_funct3(in_funct3),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we)
`ifdef WB_LOAD_TIMEOUT_EN
        , .load_err(load_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Reference load extraction from byte/half arithmetic on the raw word.
    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * off)) & 32'hFF;
        h = (d >> (16 * (off / 2))) & 32'hFFFF;
        if (f3 == 3'd0) return b >= 32'd128 ? b - 32'd256 : b;
        if (f3 == 3'd4) return b;
        if (f3 == 3'd1) return h >= 32'd32768 ? h - 32'd65536 : h;
        if (f3 == 3'd5) return h;
        return d;
    endfunction

    task automatic check_result(input string n, input logic exp_we, input logic [4:0] rd, input logic [31:0] d);
        chk({n, "_we"}, wb_we, exp_we);
        if (exp_we) begin
            chk({n, "_rd"}, wb_rd, rd);
            chk({n, "_data"}, wb_data, d);
            last_rd = rd;
            last_data = d;
        end else begin
            chk({n, "_hold_rd"}, wb_rd, last_rd);
            chk({n, "_hold_data"}, wb_data, last_data);
        end
    endtask

    task automatic op(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] pc4, input logic fl);
        chk("op_ready", in_ready, 1);
        in_valid = 1; in_rd = rd; in_reg_write = rw; in_wb_sel = sel;
        in_alu_result = alu; in_pc_plus4 = pc4; flush = fl; in_funct3 = 3'($urandom);
        @(posedge clk); #1;
        in_valid = 0; flush = 0;
        check_result("op", rw && rd != 0 && !fl, rd, sel == 2'b10 ? pc4 : alu);
        if (fl) chk("flush_ready", in_ready, 1);
    endtask

    task automatic ld(input logic [4:0] rd, input logic rw, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] d, input logic [31:0] exp_d, input int wait_n);
        chk("ld_ready", in_ready, 1);
        in_valid = 1; in_rd = rd; in_reg_write = rw; in_wb_sel = 2'b01;
        in_alu_result = addr; in_funct3 = f3; flush = 0;
        @(posedge clk); #1;
        for (int i = 0; i < wait_n; i++) begin
            in_valid = 1'($urandom); flush = 1'($urandom);
            in_wb_sel = 2'($urandom); in_rd = 5'($urandom); in_reg_write = 1;
            dmem_rdata = $urandom;
            chk("ld_wait_ready", in_ready, 0);
            chk("ld_wait_we", wb_we, 0);
            @(posedge clk); #1;
        end
        in_valid = 0; flush = 0;
        dmem_rvalid = 1; dmem_rdata = d;
        chk("ld_rvalid_ready", in_ready, 0);
        @(posedge clk); #1;
        dmem_rvalid = 0;
        check_result("ld", rw && rd != 0, rd, exp_d);
        chk("ld_ready_after", in_ready, 1);
`ifdef WB_LOAD_TIMEOUT_EN
        chk("ld_no_err", load_err, 0);
`endif
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] d;
        logic [31:0] exp;
        int          w;
    } ld_vec_t;

    initial begin
        ld_vec_t lv[10];
        lv[0] = '{3'd0, 32'h102, 32'h0080_0000, 32'hFFFF_FF80, 3};
        lv[1] = '{3'd4, 32'h102, 32'h0080_0000, 32'h0000_0080, 3};
        lv[2] = '{3'd1, 32'h202, 32'h8001_7FFF, 32'hFFFF_8001, 1};
        lv[3] = '{3'd5, 32'h202, 32'h8001_7FFF, 32'h0000_8001, 0};
        lv[4] = '{3'd2, 32'h203, 32'h8001_7FFF, 32'h8001_7FFF, 2};
        lv[5] = '{3'd3, 32'h001, 32'hCAFE_BABE, 32'hCAFE_BABE, 1};
        lv[6] = '{3'd6, 32'h002, 32'h1234_5678, 32'h1234_5678, 0};
        lv[7] = '{3'd7, 32'h003, 32'h8765_4321, 32'h8765_4321, 2};
        lv[8] = '{3'd0, 32'h003, 32'h7F00_0000, 32'h0000_007F, 1};
        lv[9] = '{3'd1, 32'h001, 32'h1234_F00D, 32'hFFFF_F00D, 1};

        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_ready", in_ready, 1);
        chk("rst_we", wb_we, 0);
        chk("rst_rd", wb_rd, 0);
        chk("rst_data", wb_data, 0);
`ifdef WB_LOAD_TIMEOUT_EN
        chk("rst_err", load_err, 0);
`endif
        op(5'd5, 1, 2'b00, 32'h0000_1234, 32'h0, 0);
        @(posedge clk); #1;
        chk("alu_we_drop", wb_we, 0);

        foreach (lv[i]) ld(5'd3 + 5'(i), 1, lv[i].f3, lv[i].addr, lv[i].d, lv[i].exp, lv[i].w);
        ld(5'd0, 1, 3'd2, 32'h0, 32'h1111_2222, 32'h1111_2222, 1);
        ld(5'd9, 0, 3'd2, 32'h0, 32'h3333_4444, 32'h3333_4444, 0);

        op(5'd1, 1, 2'b10, 32'h0000_DEAD, 32'h0000_0104, 0);
        op(5'd0, 1, 2'b10, 32'h0000_DEAD, 32'h0000_0108, 0);
        op(5'd12, 1, 2'b11, 32'hA5A5_0001, 32'h0000_0200, 0);
        op(5'd13, 0, 2'b00, 32'h0BAD_0BAD, 32'h0, 0);
        op(5'd7, 1, 2'b00, 32'h0000_0055, 32'h0, 1);
        op(5'd7, 1, 2'b01, 32'h0000_0055, 32'h0, 1);
        op(5'd14, 1, 2'b00, 32'h1, 32'h0, 0);
        op(5'd15, 1, 2'b00, 32'h2, 32'h0, 0);

        // Reset in the middle of a pending load.
        in_valid = 1; in_wb_sel = 2'b01; in_rd = 5'd8; in_reg_write = 1; in_funct3 = 3'd2;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        chk("rstld_busy", in_ready, 0);
        rst = 1; #1;
        chk("rstld_ready", in_ready, 1);
        chk("rstld_data", wb_data, 0);
        #1 rst = 0;
        last_rd = 0; last_data = 0;
        dmem_rvalid = 1; dmem_rdata = 32'hFEED_BEEF;
        @(posedge clk); #1;
        dmem_rvalid = 0;
        chk("rstld_we", wb_we, 0);
        chk("rstld_data2", wb_data, 0);
        chk("rstld_ready2", in_ready, 1);

`ifdef WB_LOAD_TIMEOUT_EN
        begin
            int first = 0, pulses = 0, wes = 0;
            in_valid = 1; in_wb_sel = 2'b01; in_rd = 5'd6; in_reg_write = 1; in_funct3 = 3'd2;
            @(posedge clk); #1;
            in_valid = 0;
            for (int i = 1; i <= 20; i++) begin
                @(posedge clk); #1;
                if (wb_we) wes++;
                if (load_err) begin
                    pulses++;
                    if (first == 0) first = i;
                end
            end
            chk("to_cycle", first, 5);
            chk("to_pulses", pulses, 1);
            chk("to_no_we", wes, 0);
            chk("to_ready", in_ready, 1);
            op(5'd10, 1, 2'b00, 32'h0000_0777, 32'h0, 0);
        end
`else
        ld(5'd11, 1, 3'd0, 32'h1, 32'h0000_8000, 32'hFFFF_FF80, 30);
`endif

        for (int k = 0; k < 300; k++) begin
            logic [31:0] d, a;
            logic [2:0]  f3;
            logic [1:0]  sel;
            logic        fl;
            d = $urandom; a = $urandom; f3 = 3'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                ld(5'($urandom), 1'($urandom), f3, a, d, load_val(f3, a[1:0], d), $urandom_range(0, 4));
            end else begin
                sel = 2'($urandom);
                fl = ($urandom_range(0, 7) == 0) || sel == 2'b01;
                op(5'($urandom), 1'($urandom), sel, a, d, fl);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
